// File: rtl/uart_bus_master_if.sv
// rtl/uart_bus_master_if.sv - peripheral bus between the UART bridge and its targets
interface uart_bus_master_if;
  logic [7:0]  address;
  logic [31:0] write_data;
  logic [31:0] read_data;
  logic        we;
  logic        re;

  modport master (
    output address,
    output write_data,
    output we,
    output re,
    input  read_data
  );

  modport slave (
    input  address,
    input  write_data,
    input  we,
    input  re,
    output read_data
  );
endinterface

// File: rtl/uart_bus_master.sv
// rtl/uart_bus_master.sv - 8N1 UART command bridge issuing single-cycle bus reads and writes
module uart_bus_master #(
  parameter int BAUD_DIV       = 434,
  parameter int TIMEOUT_CYCLES = 5000000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              uart_rx,
  output logic              uart_tx,
  uart_bus_master_if.master bus,
  output logic              busy,
  output logic              err_pulse
);

  localparam int CW = $clog2(BAUD_DIV + 1);
  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CW-1:0] FULL_M1 = CW'(BAUD_DIV - 1);
  localparam logic [CW-1:0] HALF_M1 = CW'(BAUD_DIV / 2 - 1);
  localparam logic [7:0] CMD_W = 8'h57;
  localparam logic [7:0] CMD_R = 8'h52;
  localparam logic [7:0] ACK   = 8'h06;
  localparam logic [7:0] NAK   = 8'h15;

  // ---------------- receiver ----------------
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
  rx_state_t rx_state, rx_state_nxt;
  logic          rx_s1, rx_s2, rx_prev;
  logic [CW-1:0] rx_cnt;
  logic [2:0]    rx_bit;
  logic [7:0]    rx_shift;
  logic          rx_valid, rx_ferr;
  logic          rx_half, rx_full;

  assign rx_half = (rx_cnt == HALF_M1);
  assign rx_full = (rx_cnt == FULL_M1);

  // Two-flop synchroniser plus one delayed copy for falling-edge detection
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_s1   <= 1'b1;
      rx_s2   <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_s1   <= uart_rx;
      rx_s2   <= rx_s1;
      rx_prev <= rx_s2;
    end
  end

  // RX next state: confirm start at half bit, then 8 data bits and a stop bit
  always_comb begin
    rx_state_nxt = rx_state;
    case (rx_state)
      RX_IDLE:  if (rx_prev && !rx_s2) rx_state_nxt = RX_START;
      RX_START: if (rx_half) rx_state_nxt = rx_s2 ? RX_IDLE : RX_DATA;
      RX_DATA:  if (rx_full && rx_bit == 3'd7) rx_state_nxt = RX_STOP;
      RX_STOP:  if (rx_full) rx_state_nxt = RX_IDLE;
      default:  rx_state_nxt = RX_IDLE;
    endcase
  end

  // RX datapath: bit timer, LSB-first shift register, byte/framing strobes
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_state <= RX_IDLE;
      rx_cnt   <= '0;
      rx_bit   <= 3'd0;
      rx_shift <= 8'h00;
      rx_valid <= 1'b0;
      rx_ferr  <= 1'b0;
    end else begin
      rx_state <= rx_state_nxt;
      rx_valid <= 1'b0;
      rx_ferr  <= 1'b0;
      if (rx_state == RX_IDLE || rx_state_nxt != rx_state || rx_full)
        rx_cnt <= '0;
      else
        rx_cnt <= rx_cnt + 1'b1;
      case (rx_state)
        RX_START: rx_bit <= 3'd0;
        RX_DATA: if (rx_full) begin
          rx_shift <= {rx_s2, rx_shift[7:1]};
          rx_bit   <= rx_bit + 3'd1;
        end
        RX_STOP: if (rx_full) begin
          rx_valid <= rx_s2;
          rx_ferr  <= !rx_s2;
        end
        default: ;
      endcase
    end
  end

  // ---------------- transmitter ----------------
  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
  tx_state_t tx_state, tx_state_nxt;
  logic [CW-1:0] tx_cnt;
  logic [2:0]    tx_bit;
  logic [7:0]    tx_shift;
  logic          tx_line;
  logic [31:0]   resp_buf;
  logic [2:0]    resp_cnt;
  logic          tx_full, tx_pending, tx_load, tx_idle;
  logic          buf_load;
  logic [31:0]   buf_data;
  logic [2:0]    buf_count;

  assign tx_full    = (tx_cnt == FULL_M1);
  assign tx_pending = (resp_cnt != 3'd0);
  assign tx_idle    = (tx_state == TX_IDLE) && !tx_pending;
  assign tx_load    = (tx_state_nxt == TX_START) && (tx_state != TX_START);
  assign uart_tx    = tx_line;

  // TX next state: buffered bytes go out back to back, stop bit straight into next start
  always_comb begin
    tx_state_nxt = tx_state;
    case (tx_state)
      TX_IDLE:  if (tx_pending) tx_state_nxt = TX_START;
      TX_START: if (tx_full) tx_state_nxt = TX_DATA;
      TX_DATA:  if (tx_full && tx_bit == 3'd7) tx_state_nxt = TX_STOP;
      TX_STOP:  if (tx_full) tx_state_nxt = tx_pending ? TX_START : TX_IDLE;
      default:  tx_state_nxt = TX_IDLE;
    endcase
  end

  // TX datapath: response buffer, bit timer and registered serial line
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_state <= TX_IDLE;
      tx_cnt   <= '0;
      tx_bit   <= 3'd0;
      tx_shift <= 8'h00;
      tx_line  <= 1'b1;
      resp_buf <= 32'h0;
      resp_cnt <= 3'd0;
    end else begin
      tx_state <= tx_state_nxt;
      if (tx_state == TX_IDLE || tx_full)
        tx_cnt <= '0;
      else
        tx_cnt <= tx_cnt + 1'b1;
      if (buf_load) begin
        resp_buf <= buf_data;
        resp_cnt <= buf_count;
      end else if (tx_load) begin
        tx_shift <= resp_buf[7:0];
        resp_buf <= {8'h00, resp_buf[31:8]};
        resp_cnt <= resp_cnt - 3'd1;
        tx_line  <= 1'b0;
      end
      case (tx_state)
        TX_START: if (tx_full) begin
          tx_bit  <= 3'd0;
          tx_line <= tx_shift[0];
        end
        TX_DATA: if (tx_full) begin
          if (tx_bit == 3'd7) begin
            tx_line <= 1'b1;
          end else begin
            tx_bit   <= tx_bit + 3'd1;
            tx_shift <= {1'b0, tx_shift[7:1]};
            tx_line  <= tx_shift[1];
          end
        end
        default: ;
      endcase
    end
  end

  // ---------------- command parser ----------------
  typedef enum logic [2:0] {P_CMD, P_ADDR, P_DATA, P_BUS, P_RESP} p_state_t;
  p_state_t p_state, p_state_nxt;
  logic          is_read;
  logic [1:0]    idx;
  logic [7:0]    address_q;
  logic [31:0]   write_data_q;
  logic [TW-1:0] tmo_cnt;
  logic          tmo_hit, tmo_run;
  logic          err_nxt, bus_we, bus_re;

  assign tmo_run = (p_state == P_ADDR) || (p_state == P_DATA);
  assign tmo_hit = (TIMEOUT_CYCLES != 0) && (tmo_cnt == TW'(TIMEOUT_CYCLES));

  // Parser next state, bus strobes and response loading
  always_comb begin
    p_state_nxt = p_state;
    err_nxt     = 1'b0;
    bus_we      = 1'b0;
    bus_re      = 1'b0;
    buf_load    = 1'b0;
    buf_data    = 32'h0;
    buf_count   = 3'd0;
    case (p_state)
      P_CMD: begin
        if (rx_valid) begin
          if (rx_shift == CMD_W || rx_shift == CMD_R) begin
            p_state_nxt = P_ADDR;
          end else begin
            buf_load    = 1'b1;
            buf_data    = {24'h0, NAK};
            buf_count   = 3'd1;
            err_nxt     = 1'b1;
            p_state_nxt = P_RESP;
          end
        end else if (rx_ferr) begin
          err_nxt = 1'b1;
        end
      end
      P_ADDR, P_DATA: begin
        if (rx_valid) begin
          if (p_state == P_ADDR)
            p_state_nxt = is_read ? P_BUS : P_DATA;
          else if (idx == 2'd3)
            p_state_nxt = P_BUS;
        end else if (rx_ferr || tmo_hit) begin
          err_nxt     = 1'b1;
          p_state_nxt = P_CMD;
        end
      end
      P_BUS: begin
        bus_we      = !is_read;
        bus_re      = is_read;
        buf_load    = 1'b1;
        buf_data    = is_read ? bus.read_data : {24'h0, ACK};
        buf_count   = is_read ? 3'd4 : 3'd1;
        err_nxt     = rx_valid || rx_ferr;
        p_state_nxt = P_RESP;
      end
      P_RESP: begin
        err_nxt = rx_valid || rx_ferr;
        if (tx_idle) p_state_nxt = P_CMD;
      end
      default: p_state_nxt = P_CMD;
    endcase
  end

  // Parser registers: command kind, address, write data and inter-byte timeout
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      p_state      <= P_CMD;
      err_pulse    <= 1'b0;
      is_read      <= 1'b0;
      idx          <= 2'd0;
      address_q    <= 8'h00;
      write_data_q <= 32'h0;
      tmo_cnt      <= '0;
    end else begin
      p_state   <= p_state_nxt;
      err_pulse <= err_nxt;
      if (rx_valid || !tmo_run)
        tmo_cnt <= '0;
      else if (!tmo_hit)
        tmo_cnt <= tmo_cnt + 1'b1;
      if (rx_valid) begin
        case (p_state)
          P_CMD:  is_read <= (rx_shift == CMD_R);
          P_ADDR: begin
            address_q <= rx_shift;
            idx       <= 2'd0;
          end
          P_DATA: begin
            write_data_q[{idx, 3'b000} +: 8] <= rx_shift;
            idx <= idx + 2'd1;
          end
          default: ;
        endcase
      end
    end
  end

  assign bus.address    = address_q;
  assign bus.write_data = write_data_q;
  assign bus.we         = bus_we;
  assign bus.re         = bus_re;
  assign busy           = (p_state != P_CMD) || !tx_idle;

endmodule

// File: tb/tb_uart_bus_master.sv
// tb/tb_uart_bus_master.sv - scoreboard bench for the UART bus master
module tb_uart_bus_master;
  localparam int BD = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic uart_rx = 1'b1;
  logic uart_tx, busy, err_pulse;

  uart_bus_master_if bus();

  uart_bus_master #(.BAUD_DIV(BD), .TIMEOUT_CYCLES(2000)) dut (
    .clk(clk), .rst(rst), .uart_rx(uart_rx), .uart_tx(uart_tx),
    .bus(bus), .busy(busy), .err_pulse(err_pulse)
  );

  assign bus.read_data = (bus.address == 8'h08) ? 32'h0000_0025 : 32'h0000_0000;

  always #5 clk = ~clk;

  typedef struct { bit is_wr; logic [7:0] addr; logic [31:0] data; } bus_exp_t;
  bus_exp_t   exp_bus[$];
  logic [7:0] exp_tx[$];
  int errors = 0;
  int checks = 0;
  int err_cnt = 0;
  bit mon_busy = 0;

  // bus strobe monitor
  always @(negedge clk) begin : bus_mon
    bus_exp_t e;
    if (!rst && (bus.we === 1'b1 || bus.re === 1'b1)) begin
      checks++;
      if (exp_bus.size() == 0) begin
        errors++;
        $display("FAIL bus_unexpected: we=%b re=%b addr=%h required no strobe", bus.we, bus.re, bus.address);
      end else begin
        e = exp_bus.pop_front();
        if (bus.we !== e.is_wr || bus.re !== !e.is_wr || bus.address !== e.addr ||
            (e.is_wr && bus.write_data !== e.data)) begin
          errors++;
          $display("FAIL bus_op: we=%b re=%b addr=%h wdata=%h required we=%b addr=%h wdata=%h",
                   bus.we, bus.re, bus.address, bus.write_data, e.is_wr, e.addr, e.data);
        end
      end
    end
  end

  always @(negedge clk) if (err_pulse === 1'b1) err_cnt++;

  // serial transmit decoder; bytes interrupted by reset are discarded
  initial begin : tx_mon
    logic [7:0] b;
    logic stop_bit;
    bit ab;
    forever begin
      @(negedge clk);
      if (!rst && uart_tx === 1'b0) begin
        mon_busy = 1;
        ab = 0;
        for (int k = 0; k < BD/2 - 1; k++) begin @(negedge clk); ab = ab | rst; end
        for (int i = 0; i < 8; i++) begin
          for (int k = 0; k < BD; k++) begin @(negedge clk); ab = ab | rst; end
          b[i] = uart_tx;
        end
        for (int k = 0; k < BD; k++) begin @(negedge clk); ab = ab | rst; end
        stop_bit = uart_tx;
        if (!ab) begin
          checks++;
          if (exp_tx.size() == 0) begin
            errors++;
            $display("FAIL tx_unexpected: got %h required no byte", b);
          end else if (b !== exp_tx[0] || stop_bit !== 1'b1) begin
            errors++;
            $display("FAIL tx_byte: got %h stop=%b required %h stop=1", b, stop_bit, exp_tx[0]);
            void'(exp_tx.pop_front());
          end else begin
            void'(exp_tx.pop_front());
          end
        end
        mon_busy = 0;
      end
    end
  end

  task automatic send_byte(input logic [7:0] b, input bit stop);
    @(posedge clk); #1 uart_rx = 1'b0;
    repeat (BD) @(posedge clk);
    for (int i = 0; i < 8; i++) begin
      #1 uart_rx = b[i];
      repeat (BD) @(posedge clk);
    end
    #1 uart_rx = stop;
    repeat (BD) @(posedge clk);
    #1 uart_rx = 1'b1;
    if (!stop) repeat (2 * BD) @(posedge clk);
  endtask

  task automatic wait_done(output bit timed_out);
    int n = 0;
    while ((busy !== 1'b0 || exp_tx.size() != 0 || mon_busy) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    timed_out = (n >= 3000);
    repeat (20) @(negedge clk);
  endtask

  task automatic do_read(output bit timed_out);
    exp_bus.push_back('{1'b0, 8'h08, 32'h0});
    exp_tx.push_back(8'h25); exp_tx.push_back(8'h00);
    exp_tx.push_back(8'h00); exp_tx.push_back(8'h00);
    send_byte(8'h52, 1'b1);
    send_byte(8'h08, 1'b1);
    wait_done(timed_out);
  endtask

  task automatic test_reset;
    repeat (3) @(negedge clk);
    checks++; if (uart_tx !== 1'b1) begin errors++; $display("FAIL rst_tx: got %b required 1", uart_tx); end
    checks++; if (bus.address !== 8'h00) begin errors++; $display("FAIL rst_addr: got %h required 00", bus.address); end
    checks++; if (bus.write_data !== 32'h0) begin errors++; $display("FAIL rst_wdata: got %h required 0", bus.write_data); end
    checks++; if (bus.we !== 1'b0 || bus.re !== 1'b0) begin errors++; $display("FAIL rst_strobe: we=%b re=%b required 0 0", bus.we, bus.re); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b required 0", busy); end
    checks++; if (err_pulse !== 1'b0) begin errors++; $display("FAIL rst_err: got %b required 0", err_pulse); end
    rst = 1'b0;
    repeat (5) @(negedge clk);
  endtask

  task automatic test_write;
    bit to;
    int e0 = err_cnt;
    logic [7:0] cmd [6] = '{8'h57, 8'h0C, 8'h41, 8'h00, 8'h00, 8'h00};
    exp_bus.push_back('{1'b1, 8'h0C, 32'h0000_0041});
    exp_tx.push_back(8'h06);
    foreach (cmd[i]) send_byte(cmd[i], 1'b1);
    wait_done(to);
    checks++; if (to) begin errors++; $display("FAIL write_done: timed out, required idle"); end
    checks++; if (exp_bus.size() != 0) begin errors++; $display("FAIL write_strobe: %0d strobes missing required 0", exp_bus.size()); end
    checks++; if (err_cnt != e0) begin errors++; $display("FAIL write_err: got %0d pulses required 0", err_cnt - e0); end
    checks++; if (bus.address !== 8'h0C || bus.write_data !== 32'h41) begin
      errors++; $display("FAIL write_hold: addr=%h wdata=%h required 0c 00000041", bus.address, bus.write_data);
    end
  endtask

  task automatic test_read;
    bit to;
    int e0 = err_cnt;
    do_read(to);
    checks++; if (to) begin errors++; $display("FAIL read_done: timed out, required idle"); end
    checks++; if (exp_bus.size() != 0) begin errors++; $display("FAIL read_strobe: %0d strobes missing required 0", exp_bus.size()); end
    checks++; if (err_cnt != e0) begin errors++; $display("FAIL read_err: got %0d pulses required 0", err_cnt - e0); end
  endtask

  task automatic test_bad_cmd;
    bit to;
    int e0 = err_cnt;
    exp_tx.push_back(8'h15);
    send_byte(8'h33, 1'b1);
    wait_done(to);
    checks++; if (to) begin errors++; $display("FAIL badcmd_done: timed out, required idle"); end
    checks++; if (err_cnt != e0 + 1) begin errors++; $display("FAIL badcmd_err: got %0d pulses required 1", err_cnt - e0); end
    do_read(to);
    checks++; if (to || exp_bus.size() != 0) begin errors++; $display("FAIL badcmd_read: timeout=%b missing=%0d required 0 0", to, exp_bus.size()); end
  endtask

  task automatic test_framing;
    bit to;
    int e0 = err_cnt;
    send_byte(8'h57, 1'b0);
    repeat (20) @(negedge clk);
    checks++; if (err_cnt != e0 + 1) begin errors++; $display("FAIL frame_err: got %0d pulses required 1", err_cnt - e0); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL frame_busy: got %b required 0", busy); end
    do_read(to);
    checks++; if (to || exp_bus.size() != 0) begin errors++; $display("FAIL frame_read: timeout=%b missing=%0d required 0 0", to, exp_bus.size()); end
    checks++; if (err_cnt != e0 + 1) begin errors++; $display("FAIL frame_read_err: got %0d pulses required 1", err_cnt - e0); end
  endtask

  task automatic test_timeout;
    bit to;
    int e0 = err_cnt;
    send_byte(8'h57, 1'b1);
    send_byte(8'h0C, 1'b1);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL tmo_pending: busy=%b required 1", busy); end
    repeat (2100) @(negedge clk);
    checks++; if (err_cnt != e0 + 1) begin errors++; $display("FAIL tmo_err: got %0d pulses required 1", err_cnt - e0); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL tmo_busy: got %b required 0", busy); end
    do_read(to);
    checks++; if (to || exp_bus.size() != 0) begin errors++; $display("FAIL tmo_read: timeout=%b missing=%0d required 0 0", to, exp_bus.size()); end
  endtask

  task automatic test_reset_mid_response;
    bit to;
    int n = 0;
    exp_bus.push_back('{1'b0, 8'h08, 32'h0});
    exp_tx.push_back(8'h25);
    send_byte(8'h52, 1'b1);
    send_byte(8'h08, 1'b1);
    while (exp_tx.size() != 0 && n < 1000) begin @(negedge clk); n++; end
    checks++; if (n >= 1000) begin errors++; $display("FAIL rstmid_first: first reply byte not seen"); end
    repeat (40) @(negedge clk);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rstmid_active: busy=%b required 1", busy); end
    #2 rst = 1'b1;
    #1;
    checks++; if (uart_tx !== 1'b1) begin errors++; $display("FAIL rstmid_tx: got %b required 1", uart_tx); end
    checks++; if (bus.address !== 8'h00 || bus.write_data !== 32'h0 || bus.we !== 1'b0 || bus.re !== 1'b0) begin
      errors++; $display("FAIL rstmid_bus: addr=%h wdata=%h we=%b re=%b required 00 0 0 0", bus.address, bus.write_data, bus.we, bus.re);
    end
    checks++; if (busy !== 1'b0 || err_pulse !== 1'b0) begin errors++; $display("FAIL rstmid_flags: busy=%b err=%b required 0 0", busy, err_pulse); end
    repeat (3) @(negedge clk);
    rst = 1'b0;
    n = 0;
    while (mon_busy && n < 1000) begin @(negedge clk); n++; end
    repeat (5) @(negedge clk);
    do_read(to);
    checks++; if (to || exp_bus.size() != 0) begin errors++; $display("FAIL rstmid_read: timeout=%b missing=%0d required 0 0", to, exp_bus.size()); end
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_bad_cmd();
    test_framing();
    test_timeout();
    test_reset_mid_response();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end
endmodule
